sys_mng_drp_responder: RTL
==========================

Name: sys_mng_drp_responder

Overview:
- DRP responder (slave) that emulates the system-monitor register map, i.e. the target end of the DRP bus driven by the sensor-poll controller.
- Holds the live measurement registers fed from ports, running min/max registers and a writable config RAM.
- Answers DRP reads and writes with a programmable-latency DRP_RDY.
- Used as a simulation/bring-up stand-in, and on parts or regions without a hard sensor block.

Parameters:
- RDY_LATENCY, 4, cycles from accepted DRP_EN to the DRP_RDY pulse; legal range 1..15.
- CFG_DEPTH, 64, number of 16-bit config words mapped at 0x40..0x40+CFG_DEPTH-1; maximum 64.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- DRP_ADDR  in  8  register address, sampled on an accepted DRP_EN
- DRP_DI  in  16  write data, sampled on an accepted DRP_EN
- DRP_EN  in  1  single-cycle transaction request
- DRP_WE  in  1  write qualifier, sampled with DRP_EN
- DRP_DO  out  16  read data, valid only while DRP_RDY=1
- DRP_RDY  out  1  single-cycle completion pulse
- MEAS_VALID  in  1  strobe: update all measurement registers this cycle
- MEAS_TEMP / MEAS_VCCINT / MEAS_VCCAUX / MEAS_VCCBRAM  in  16 each  new sample values
- PROTO_ERR  out  1  single-cycle pulse when DRP_EN arrives while busy

Behaviour:
- Reset: asynchronous, active-high. While RESET=1 and after release:
  - DRP_DO=0, DRP_RDY=0, PROTO_ERR=0, FSM in IDLE.
  - Measurement regs = 0x0000; max regs = 0x0000; min regs = 0xFFFF; config RAM = 0x0000.
  - RESET mid-transaction drops the pending RDY; no RDY is issued after release.
- Address map (all other addresses read 0x0000 and ignore writes):
  - 0x00 TEMP, 0x01 VCCINT, 0x02 VCCAUX, 0x06 VCCBRAM.
  - 0x20..0x23 max of TEMP/VCCINT/VCCAUX/VCCBRAM.
  - 0x24..0x27 min of TEMP/VCCINT/VCCAUX/VCCBRAM.
  - 0x40..0x40+CFG_DEPTH-1 config RAM, read/write.
  - Measurement, min and max registers are read-only; writes to them are acknowledged and discarded.
- FSM states: IDLE and WAIT.
  - IDLE: when DRP_EN=1, the transaction is accepted at edge t. Read data is snapshotted from register state before edge t. A write commits to the config RAM at edge t. The latency counter loads RDY_LATENCY-1 and the FSM goes to WAIT.
  - WAIT: the counter decrements each cycle. DRP_RDY=1 exactly in cycle t+RDY_LATENCY, for one cycle, with DRP_DO = snapshot for reads and 0x0000 for writes. The FSM returns to IDLE at the end of the RDY cycle.
  - RDY_LATENCY=1: the RDY cycle immediately follows the EN cycle.
- Busy window: the cycle after acceptance through the RDY cycle inclusive.
  - DRP_EN inside the busy window, including the RDY cycle itself, is ignored: no state change, no extra RDY. PROTO_ERR pulses in the following cycle.
  - Back-to-back throughput: the next DRP_EN is accepted no earlier than the cycle after RDY.
- DRP_DO is 0x0000 whenever DRP_RDY=0.
- Measurement update on MEAS_VALID=1:
  - All four measurement registers load the inputs at that edge.
  - max := input if input > max (unsigned compare); min := input if input < min (unsigned compare).
  - Equal values leave min/max unchanged.
  - A read accepted in the same cycle returns the pre-update values.
- Simultaneous MEAS_VALID and DRP write to a read-only address: MEAS_VALID wins; the write is discarded.

Decomposition:
- Package sys_mng_drp_pkg holds:
  - Address localparams (ADDR_TEMP, ADDR_VCCINT, ADDR_VCCAUX, ADDR_VCCBRAM, ADDR_MAX_BASE, ADDR_MIN_BASE, ADDR_CFG_BASE).
  - The FSM state enum (IDLE, WAIT).
  - MIN_RESET=16'hFFFF and MAX_RESET=16'h0000.
- Sub-module sys_mng_minmax_track, instantiated once per channel (4×):
  - Inputs: CLK, RESET, valid, sample.
  - Outputs: cur, max, min registers.

Test Plan:
- Reset, then read 0x24 with RDY_LATENCY=4 (EN at cycle 10) -> RDY only in cycle 14, DO=0xFFFF; DO=0 in all other cycles.
- MEAS_VALID with TEMP=0x9A30, then TEMP=0x8000; read 0x00, 0x20, 0x24 -> 0x8000, 0x9A30, 0x8000.
- Write 0x1234 to 0x41, then read 0x41 -> write RDY with DO=0; read returns 0x1234. Read of 0x7F (CFG_DEPTH=64) returns 0x0000; read of 0x10 returns 0x0000.
- Read 0x01 with MEAS_VALID (VCCINT=0x5555) in the same cycle, prior value 0x4000 -> DO=0x4000; a subsequent read returns 0x5555.
- DRP_EN in cycle t+2 and again in the RDY cycle t+4 -> exactly one RDY; PROTO_ERR pulses in t+3 and t+5; config RAM unchanged by the ignored writes.
- Assert RESET at t+2 of a read -> no RDY; after release, read 0x20 returns 0x0000.

Source files
------------

// File: rtl/sys_mng_drp_pkg.sv
// Shared definitions for the system-monitor DRP responder: register map, FSM states, min/max reset values.
package sys_mng_drp_pkg;

  localparam logic [7:0] ADDR_TEMP     = 8'h00;
  localparam logic [7:0] ADDR_VCCINT   = 8'h01;
  localparam logic [7:0] ADDR_VCCAUX   = 8'h02;
  localparam logic [7:0] ADDR_VCCBRAM  = 8'h06;
  localparam logic [7:0] ADDR_MAX_BASE = 8'h20;
  localparam logic [7:0] ADDR_MIN_BASE = 8'h24;
  localparam logic [7:0] ADDR_CFG_BASE = 8'h40;

  localparam logic [15:0] MIN_RESET = 16'hFFFF;
  localparam logic [15:0] MAX_RESET = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } drp_state_t;

  // The config window starts on a 64-word boundary, so bits [5:0] are the word index.
  function automatic logic is_cfg_addr(input logic [7:0] addr, input int depth);
    return (addr[7:6] == ADDR_CFG_BASE[7:6]) && (int'(addr[5:0]) < depth);
  endfunction

endpackage

// File: rtl/sys_mng_drp_responder_if.sv
// DRP bus between the sensor-poll controller (master) and the register-map responder (slave).
interface sys_mng_drp_responder_if;
  logic [7:0]  DRP_ADDR;
  logic [15:0] DRP_DI;
  logic        DRP_EN;
  logic        DRP_WE;
  logic [15:0] DRP_DO;
  logic        DRP_RDY;

  modport master (
    output DRP_ADDR, DRP_DI, DRP_EN, DRP_WE,
    input  DRP_DO, DRP_RDY
  );

  modport slave (
    input  DRP_ADDR, DRP_DI, DRP_EN, DRP_WE,
    output DRP_DO, DRP_RDY
  );
endinterface

// File: rtl/sys_mng_minmax_track.sv
// One measurement channel: live value plus running unsigned max/min, updated on each valid strobe.
module sys_mng_minmax_track
  import sys_mng_drp_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_valid,
  input  logic [15:0] i_sample,
  output logic [15:0] o_cur,
  output logic [15:0] o_max,
  output logic [15:0] o_min
);

  logic [15:0] r_cur;
  logic [15:0] r_max;
  logic [15:0] r_min;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cur <= 16'h0000;
      r_max <= MAX_RESET;
      r_min <= MIN_RESET;
    end else if (i_valid) begin
      r_cur <= i_sample;
      if (i_sample > r_max) r_max <= i_sample;
      if (i_sample < r_min) r_min <= i_sample;
    end
  end

  assign o_cur = r_cur;
  assign o_max = r_max;
  assign o_min = r_min;

endmodule

// File: rtl/sys_mng_drp_responder.sv
// DRP slave emulating the system-monitor register map: live/min/max sensor registers plus a config RAM,
// answering each accepted request with a single DRP_RDY pulse RDY_LATENCY cycles later.
module sys_mng_drp_responder
  import sys_mng_drp_pkg::*;
#(
  parameter int RDY_LATENCY = 4,
  parameter int CFG_DEPTH   = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sys_mng_drp_responder_if.slave drp,
  input  logic                   MEAS_VALID,
  input  logic [15:0]            MEAS_TEMP,
  input  logic [15:0]            MEAS_VCCINT,
  input  logic [15:0]            MEAS_VCCAUX,
  input  logic [15:0]            MEAS_VCCBRAM,
  output logic                   PROTO_ERR
);

  localparam logic [3:0] LAT_LOAD = 4'(RDY_LATENCY - 1);

  logic [15:0] w_samp [4];
  logic [15:0] w_cur  [4];
  logic [15:0] w_max  [4];
  logic [15:0] w_min  [4];

  assign w_samp[0] = MEAS_TEMP;
  assign w_samp[1] = MEAS_VCCINT;
  assign w_samp[2] = MEAS_VCCAUX;
  assign w_samp[3] = MEAS_VCCBRAM;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    sys_mng_minmax_track u_trk (
      .CLK      (CLK),
      .RESET    (RESET),
      .i_valid  (MEAS_VALID),
      .i_sample (w_samp[g]),
      .o_cur    (w_cur[g]),
      .o_max    (w_max[g]),
      .o_min    (w_min[g])
    );
  end

  drp_state_t  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_snap;
  logic [15:0] r_do;
  logic        r_rdy;
  logic        r_perr;
  // Sized to the full window; words at or above CFG_DEPTH are never written and stay at reset.
  logic [15:0] r_cfg [64];

  logic        w_cfg_hit;
  logic [15:0] w_rd_dat;
  logic [15:0] w_resp;

  assign w_cfg_hit = is_cfg_addr(drp.DRP_ADDR, CFG_DEPTH);

  always_comb begin
    w_rd_dat = 16'h0000;
    case (drp.DRP_ADDR)
      ADDR_TEMP:             w_rd_dat = w_cur[0];
      ADDR_VCCINT:           w_rd_dat = w_cur[1];
      ADDR_VCCAUX:           w_rd_dat = w_cur[2];
      ADDR_VCCBRAM:          w_rd_dat = w_cur[3];
      ADDR_MAX_BASE:         w_rd_dat = w_max[0];
      ADDR_MAX_BASE + 8'd1:  w_rd_dat = w_max[1];
      ADDR_MAX_BASE + 8'd2:  w_rd_dat = w_max[2];
      ADDR_MAX_BASE + 8'd3:  w_rd_dat = w_max[3];
      ADDR_MIN_BASE:         w_rd_dat = w_min[0];
      ADDR_MIN_BASE + 8'd1:  w_rd_dat = w_min[1];
      ADDR_MIN_BASE + 8'd2:  w_rd_dat = w_min[2];
      ADDR_MIN_BASE + 8'd3:  w_rd_dat = w_min[3];
      default: begin
        if (w_cfg_hit) w_rd_dat = r_cfg[drp.DRP_ADDR[5:0]];
      end
    endcase
  end

  assign w_resp = drp.DRP_WE ? 16'h0000 : w_rd_dat;

  // Counter reaching 1 schedules the RDY pulse; the RDY cycle itself sees 0 and returns to IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_snap  <= 16'h0000;
      r_do    <= 16'h0000;
      r_rdy   <= 1'b0;
      r_perr  <= 1'b0;
      for (int i = 0; i < 64; i++) r_cfg[i] <= 16'h0000;
    end else begin
      r_perr <= drp.DRP_EN && (r_state == WAIT);
      r_rdy  <= 1'b0;
      r_do   <= 16'h0000;
      case (r_state)
        IDLE: begin
          if (drp.DRP_EN) begin
            r_snap  <= w_resp;
            r_cnt   <= LAT_LOAD;
            r_state <= WAIT;
            if (drp.DRP_WE && w_cfg_hit) r_cfg[drp.DRP_ADDR[5:0]] <= drp.DRP_DI;
            if (RDY_LATENCY == 1) begin
              r_rdy <= 1'b1;
              r_do  <= w_resp;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_rdy <= 1'b1;
              r_do  <= r_snap;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign drp.DRP_DO  = r_do;
  assign drp.DRP_RDY = r_rdy;
  assign PROTO_ERR   = r_perr;

endmodule
